// File: rtl/sys_debug_ctrl_if.sv
// Board-side control bundle between the debug front end and the panel/CPU side.
// master = board/panel side driving raw controls, slave = the debug controller.
interface sys_debug_ctrl_if;
    logic       btn_step;
    logic       btn_sel;
    logic       btn_load;
    logic       sw_run;
    logic [7:0] sw_pc;
    logic       step_en;
    logic       SYS_load;
    logic [7:0] SYS_pc_val;
    logic [7:0] SYS_output_sel;
    logic       run_active;

    modport master (
        output btn_step, btn_sel, btn_load, sw_run, sw_pc,
        input  step_en, SYS_load, SYS_pc_val, SYS_output_sel, run_active
    );

    modport slave (
        input  btn_step, btn_sel, btn_load, sw_run, sw_pc,
        output step_en, SYS_load, SYS_pc_val, SYS_output_sel, run_active
    );
endinterface

// File: rtl/sys_debug_ctrl.sv
// Debug front end for the single-cycle CPU: conditions the panel buttons and
// generates step / PC-load / view-select controls in manual or free-run mode.
module sys_debug_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 8,
    parameter int SEL_MAX         = 7
) (
    input logic             SYS_clk,
    input logic             SYS_reset,
    sys_debug_ctrl_if.slave dbg
);
    localparam int NUM_IN   = 4;
    localparam int IDX_STEP = 0;
    localparam int IDX_SEL  = 1;
    localparam int IDX_LOAD = 2;
    localparam int IDX_RUN  = 3;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PRE_W    = $clog2(RUN_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RUN_DIV - 1);
    localparam logic [7:0]       SEL_LAST = 8'(SEL_MAX);

    typedef enum logic [1:0] {ST_MANUAL, ST_LOAD, ST_RUN} state_t;

    logic [NUM_IN-1:0] raw, sync1, sync2, stable, stable_q, press;
    logic [CNT_W-1:0]  db_cnt [NUM_IN];
    logic              run_lvl;

    state_t            state, next_state;
    logic [PRE_W-1:0]  presc, presc_d;
    logic              step_en_d, load_d;

    logic              step_en_q, load_q, run_active_q;
    logic [7:0]        pc_val_q, sel_q;

    assign raw = {dbg.sw_run, dbg.btn_load, dbg.btn_sel, dbg.btn_step};

    // Two-flop synchronizer followed by a per-input stability counter.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < NUM_IN; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep sync1->sync2 a true two-stage pipeline.
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press   = stable & ~stable_q;
    assign run_lvl = stable[IDX_RUN];

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) state <= ST_MANUAL;
        else           state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_MANUAL: begin
                if (run_lvl)               next_state = ST_RUN;
                else if (press[IDX_LOAD])  next_state = ST_LOAD;
            end
            ST_LOAD:                       next_state = ST_MANUAL;
            ST_RUN: begin
                if (!run_lvl)              next_state = ST_MANUAL;
            end
            default:                       next_state = ST_MANUAL;
        endcase
    end

    // Next-cycle pulse values; run > load > step, losers are simply dropped.
    always_comb begin
        step_en_d = 1'b0;
        load_d    = 1'b0;
        presc_d   = '0;
        case (state)
            ST_MANUAL: begin
                load_d    = !run_lvl && press[IDX_LOAD];
                step_en_d = !run_lvl && !press[IDX_LOAD] && press[IDX_STEP];
            end
            ST_RUN: begin
                if (run_lvl) begin
                    step_en_d = (presc == PRE_LAST);
                    presc_d   = (presc == PRE_LAST) ? '0 : presc + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            presc        <= '0;
            step_en_q    <= 1'b0;
            load_q       <= 1'b0;
            run_active_q <= 1'b0;
            pc_val_q     <= '0;
            sel_q        <= '0;
        end else begin
            presc        <= presc_d;
            step_en_q    <= step_en_d;
            load_q       <= load_d;
            run_active_q <= (next_state == ST_RUN);
            if (load_d) pc_val_q <= dbg.sw_pc;
            // View selector advances on its own, whatever the FSM is doing.
            if (press[IDX_SEL]) sel_q <= (sel_q == SEL_LAST) ? 8'd0 : sel_q + 8'd1;
        end
    end

    assign dbg.step_en        = step_en_q;
    assign dbg.SYS_load       = load_q;
    assign dbg.SYS_pc_val     = pc_val_q;
    assign dbg.SYS_output_sel = sel_q;
    assign dbg.run_active     = run_active_q;
endmodule

// File: tb/tb_sys_debug_ctrl.sv
// Self-checking bench for sys_debug_ctrl: a negedge monitor logs output events
// into a queue that each scenario compares against the events it expects.
module tb_sys_debug_ctrl;
    localparam int DB = 16;
    localparam int RD = 8;
    localparam int SM = 7;

    typedef enum logic [1:0] {EV_STEP, EV_LOAD, EV_SEL, EV_RUN} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   sel_model = 0;
    logic [7:0] prev_sel;
    logic       prev_run;

    ev_t obs_q[$];
    ev_t exp_q[$];

    sys_debug_ctrl_if dbg ();

    sys_debug_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (RD),
        .SEL_MAX        (SM)
    ) dut (
        .SYS_clk  (clk),
        .SYS_reset(rst),
        .dbg      (dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_sel = 8'd0;
            prev_run = 1'b0;
        end else begin
            if (dbg.step_en)  obs_q.push_back('{EV_STEP, 8'h00, cyc});
            if (dbg.SYS_load) obs_q.push_back('{EV_LOAD, dbg.SYS_pc_val, cyc});
            if (dbg.SYS_output_sel != prev_sel) obs_q.push_back('{EV_SEL, dbg.SYS_output_sel, cyc});
            if (dbg.run_active != prev_run) obs_q.push_back('{EV_RUN, {7'd0, dbg.run_active}, cyc});
            prev_sel = dbg.SYS_output_sel;
            prev_run = dbg.run_active;
            checks++;
            if (dbg.step_en && dbg.SYS_load) begin
                errors++;
                $display("FAIL pulse_overlap: step_en and SYS_load both high at cycle %0d, required never together", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion within time limit");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: dbg.btn_step = v;
            1: dbg.btn_sel  = v;
            2: dbg.btn_load = v;
            default: dbg.sw_run = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        idle(DB + 6);
        set_btn(which, 1'b0);
        idle(DB + 6);
    endtask

    task automatic test_reset;
        #3;
        checks++; if (dbg.step_en !== 1'b0)        begin errors++; $display("FAIL rst_step_en: got %b required 0", dbg.step_en); end
        checks++; if (dbg.SYS_load !== 1'b0)       begin errors++; $display("FAIL rst_load: got %b required 0", dbg.SYS_load); end
        checks++; if (dbg.SYS_pc_val !== 8'h00)    begin errors++; $display("FAIL rst_pc_val: got %h required 00", dbg.SYS_pc_val); end
        checks++; if (dbg.SYS_output_sel !== 8'h00) begin errors++; $display("FAIL rst_sel: got %h required 00", dbg.SYS_output_sel); end
        checks++; if (dbg.run_active !== 1'b0)     begin errors++; $display("FAIL rst_run_active: got %b required 0", dbg.run_active); end
        idle(3);
        rst = 1'b0;
        idle(5);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d events required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_sel_wrap;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            press(1);
            sel_model = (sel_model == SM) ? 0 : sel_model + 1;
            exp_q.push_back('{EV_SEL, 8'(sel_model), 0});
        end
        idle(2);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sel_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL sel_seq[%0d]: got kind %0d value %0d required kind %0d value %0d",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_debounce;
        int t_rise;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            dbg.btn_step = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        dbg.btn_step = 1'b1;
        t_rise = cyc;
        exp_q.push_back('{EV_STEP, 8'h00, t_rise + 2 + DB});
        idle(30);
        dbg.btn_step = 1'b0;
        idle(30);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL debounce_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind ||
                obs_q[i].cyc < exp_q[i].cyc - 1 || obs_q[i].cyc > exp_q[i].cyc + 1) begin
                errors++;
                $display("FAIL debounce_pulse: got kind %0d at +%0d cycles required kind %0d at +%0d +/-1",
                         obs_q[i].kind, obs_q[i].cyc - t_rise, exp_q[i].kind, exp_q[i].cyc - t_rise);
            end
        end
    endtask

    task automatic test_load;
        obs_q.delete();
        exp_q.delete();
        dbg.sw_pc    = 8'hA4;
        dbg.btn_load = 1'b1;
        dbg.btn_step = 1'b1;
        exp_q.push_back('{EV_LOAD, 8'hA4, 0});
        idle(DB + 6);
        dbg.btn_load = 1'b0;
        dbg.btn_step = 1'b0;
        idle(DB + 6);
        checks++;
        if (dbg.SYS_pc_val !== 8'hA4) begin
            errors++;
            $display("FAIL load_pc_val: got %h required a4", dbg.SYS_pc_val);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL load_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL load_event[%0d]: got kind %0d data %h required kind %0d data %h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_coincidence;
        obs_q.delete();
        exp_q.delete();
        dbg.sw_pc = 8'h3C;
        set_btn(0, 1'b1);
        set_btn(2, 1'b1);
        exp_q.push_back('{EV_LOAD, 8'h3C, 0});
        idle(DB + 6);
        set_btn(0, 1'b0);
        set_btn(2, 1'b0);
        idle(DB + 6);
        dbg.sw_pc = 8'hFF;
        press(0);
        exp_q.push_back('{EV_STEP, 8'h00, 0});
        checks++;
        if (dbg.SYS_pc_val !== 8'h3C) begin
            errors++;
            $display("FAIL coinc_pc_hold: got %h required 3c", dbg.SYS_pc_val);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL coinc_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL coinc_event[%0d]: got kind %0d data %h required kind %0d data %h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_run;
        int t_on, t_off, rise, fall, loads, sels;
        int steps[$];
        obs_q.delete();
        exp_q.delete();
        rise = -1; fall = -1; loads = 0; sels = 0;
        dbg.sw_run = 1'b1;
        t_on = cyc;
        idle(40);
        checks++;
        if (dbg.run_active !== 1'b1) begin
            errors++;
            $display("FAIL run_active_on: got %b required 1", dbg.run_active);
        end
        dbg.btn_load = 1'b1;
        dbg.btn_sel  = 1'b1;
        idle(25);
        dbg.btn_load = 1'b0;
        dbg.btn_sel  = 1'b0;
        idle(25);
        sel_model = (sel_model == SM) ? 0 : sel_model + 1;
        idle(110);
        dbg.sw_run = 1'b0;
        t_off = cyc;
        idle(40);
        checks++;
        if (dbg.run_active !== 1'b0) begin
            errors++;
            $display("FAIL run_active_off: got %b required 0", dbg.run_active);
        end
        foreach (obs_q[i]) begin
            case (obs_q[i].kind)
                EV_RUN:  if (obs_q[i].data[0]) rise = obs_q[i].cyc; else fall = obs_q[i].cyc;
                EV_STEP: steps.push_back(obs_q[i].cyc);
                EV_LOAD: loads++;
                default: begin
                    sels++;
                    checks++;
                    if (obs_q[i].data !== 8'(sel_model)) begin
                        errors++;
                        $display("FAIL run_sel_value: got %0d required %0d", obs_q[i].data, sel_model);
                    end
                end
            endcase
        end
        checks++;
        if (rise < t_on + DB + 2 || rise > t_on + DB + 4) begin
            errors++;
            $display("FAIL run_entry: got +%0d cycles required %0d..%0d", rise - t_on, DB + 2, DB + 4);
        end
        checks++;
        if (fall < t_off + DB + 2 || fall > t_off + DB + 4) begin
            errors++;
            $display("FAIL run_exit: got +%0d cycles required %0d..%0d", fall - t_off, DB + 2, DB + 4);
        end
        checks++;
        if (loads != 0) begin
            errors++;
            $display("FAIL run_load_ignored: got %0d loads required 0", loads);
        end
        checks++;
        if (sels != 1) begin
            errors++;
            $display("FAIL run_sel_count: got %0d selector changes required 1", sels);
        end
        for (int t = rise + RD; t < fall; t += RD) exp_q.push_back('{EV_STEP, 8'h00, t});
        checks++;
        if (steps.size() != exp_q.size() || steps.size() < 15) begin
            errors++;
            $display("FAIL run_step_count: got %0d pulses required %0d (at least 15)", steps.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < steps.size(); i++) begin
            checks++;
            if (steps[i] != exp_q[i].cyc) begin
                errors++;
                $display("FAIL run_step[%0d]: got cycle %0d required cycle %0d", i, steps[i], exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        obs_q.delete();
        exp_q.delete();
        dbg.sw_run = 1'b1;
        for (int i = 0; i < 60 && !dbg.run_active; i++) @(negedge clk);
        checks++;
        if (dbg.run_active !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_entry: run_active %b required 1 within 60 cycles", dbg.run_active);
        end
        idle(5);
        rst = 1'b1;
        #1;
        checks++; if (dbg.step_en !== 1'b0)        begin errors++; $display("FAIL mid_rst_step_en: got %b required 0", dbg.step_en); end
        checks++; if (dbg.SYS_load !== 1'b0)       begin errors++; $display("FAIL mid_rst_load: got %b required 0", dbg.SYS_load); end
        checks++; if (dbg.SYS_pc_val !== 8'h00)    begin errors++; $display("FAIL mid_rst_pc_val: got %h required 00", dbg.SYS_pc_val); end
        checks++; if (dbg.SYS_output_sel !== 8'h00) begin errors++; $display("FAIL mid_rst_sel: got %h required 00", dbg.SYS_output_sel); end
        checks++; if (dbg.run_active !== 1'b0)     begin errors++; $display("FAIL mid_rst_run_active: got %b required 0", dbg.run_active); end
        dbg.sw_run = 1'b0;
        sel_model = 0;
        idle(2);
        rst = 1'b0;
        obs_q.delete();
        idle(RD + 4);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_rst_quiet: got %0d events required 0", obs_q.size());
        end
        press(0);
        exp_q.push_back('{EV_STEP, 8'h00, 0});
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_rst_manual: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind) begin
                errors++;
                $display("FAIL mid_rst_manual_kind: got %0d required %0d", obs_q[i].kind, exp_q[i].kind);
            end
        end
    endtask

    initial begin
        dbg.btn_step = 1'b0;
        dbg.btn_sel  = 1'b0;
        dbg.btn_load = 1'b0;
        dbg.sw_run   = 1'b0;
        dbg.sw_pc    = 8'h00;
        #1 rst = 1'b1;
        test_reset();
        test_sel_wrap();
        test_debounce();
        test_load();
        test_coincidence();
        test_run();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
